multi_sensor_arbiter: RTL and testbench

Parametrised N-channel successor to the three-sensor priority arbiter. Each sensor channel has its own small ingress FIFO, so simultaneous or back-to-back samples are queued rather than lost. Arbitration is selectable at run time between fixed priority and round-robin. The block sits between the sensor front-ends and the packet/serialiser stage and drives a single ready/valid stream tagged with the channel ID.

---
 rtl/iot_sensor_pkg.sv | 15 +
 rtl/sensor_chan_fifo.sv | 61 ++++++
 rtl/multi_sensor_arbiter.sv | 121 ++++++++++++
 tb/tb_multi_sensor_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iot_sensor_pkg.sv
// rtl/iot_sensor_pkg.sv - shared types and channel constants for the sensor arbiter
// Purpose: arbitration mode enum and fixed channel assignments.
// Ports: none (package).
package iot_sensor_pkg;

  typedef enum logic {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  localparam int CH_MOTION      = 0;
  localparam int CH_TEMPERATURE = 1;
  localparam int CH_HUMIDITY    = 2;

endpackage

// File: rtl/sensor_chan_fifo.sv
// rtl/sensor_chan_fifo.sv - per-channel ingress FIFO
// Purpose: small circular buffer holding samples for one sensor channel.
// Ports: clk, rst (async, active high); push/wdata write side; pop/rdata read
//        side (rdata shows the head entry); full, empty and registered count.
module sensor_chan_fifo #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [DATA_W-1:0]            wdata,
  output logic [DATA_W-1:0]            rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/multi_sensor_arbiter.sv
// rtl/multi_sensor_arbiter.sv - N-channel sensor arbiter with per-channel FIFOs
// Purpose: queues samples per channel and emits them one beat at a time on a
//          ready/valid stream tagged with the channel index.
// Ports: clk, rst (async, active high); enable; mode (fixed / round-robin);
//        clr_error; in_data/in_valid/in_ready per channel; out_data/out_id/
//        out_valid/out_ready stream; pending per channel; overflow_error.
module multi_sensor_arbiter
  import iot_sensor_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  arb_mode_e                    mode,
  input  logic                         clr_error,
  input  logic [NUM_CH*DATA_W-1:0]     in_data,
  input  logic [NUM_CH-1:0]            in_valid,
  output logic [NUM_CH-1:0]            in_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(NUM_CH)-1:0]    out_id,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NUM_CH-1:0]            pending,
  output logic                         overflow_error
);

  localparam int ID_W  = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [DATA_W-1:0] rdata [NUM_CH];
  logic [CNT_W-1:0]  count [NUM_CH];

  logic [ID_W-1:0]   last_grant;
  logic [ID_W-1:0]   grant_id;
  logic [ID_W-1:0]   rr_idx;
  logic              grant_found;
  logic              slot_free;
  logic              slot_load;
  logic              ovf_set;

  // in_ready is forced low during reset rather than only after it.
  assign in_ready  = {NUM_CH{enable & ~rst}} & ~full;
  assign push      = in_valid & in_ready;
  assign ovf_set   = enable & |(in_valid & ~in_ready);
  assign slot_free = enable & (~out_valid | out_ready);
  assign slot_load = slot_free & grant_found;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    sensor_chan_fifo #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[gi]),
      .pop   (pop[gi]),
      .wdata (in_data[gi*DATA_W +: DATA_W]),
      .rdata (rdata[gi]),
      .full  (full[gi]),
      .empty (empty[gi]),
      .count (count[gi])
    );
    assign pending[gi] = (count[gi] != '0);
    assign pop[gi]     = slot_load & (grant_id == ID_W'(gi));
  end

  // Loops run from lowest to highest priority so the last hit is the winner.
  // In round-robin, offset 1 from last_grant is highest and offset NUM_CH
  // (last_grant itself) is lowest.
  always_comb begin
    grant_found = 1'b0;
    grant_id    = '0;
    rr_idx      = '0;
    if (mode == ARB_FIXED) begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        if (!empty[k]) begin
          grant_found = 1'b1;
          grant_id    = ID_W'(k);
        end
      end
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        rr_idx = ID_W'((int'(last_grant) + k) % NUM_CH);
        if (!empty[rr_idx]) begin
          grant_found = 1'b1;
          grant_id    = rr_idx;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_data       <= '0;
      out_id         <= '0;
      last_grant     <= ID_W'(NUM_CH - 1);
      overflow_error <= 1'b0;
    end else begin
      if (slot_load) begin
        out_valid  <= 1'b1;
        out_data   <= rdata[grant_id];
        out_id     <= grant_id;
        last_grant <= grant_id;
      end else if (out_valid && out_ready) begin
        out_valid  <= 1'b0;
      end

      if (ovf_set)        overflow_error <= 1'b1;
      else if (clr_error) overflow_error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_sensor_arbiter.sv
// tb/tb_multi_sensor_arbiter.sv - directed scoreboard bench for multi_sensor_arbiter
module tb_multi_sensor_arbiter;
  import iot_sensor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        clr_error = 1'b0;
  logic        out_ready = 1'b0;
  arb_mode_e   mode = ARB_FIXED;
  logic [47:0] in_data = '0;
  logic [2:0]  in_valid = '0;
  logic [2:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_id;
  logic        out_valid;
  logic [2:0]  pending;
  logic        overflow_error;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  id;
    logic [15:0] data;
  } beat_t;

  beat_t sb[$];
  beat_t mb;

  multi_sensor_arbiter #(
    .NUM_CH (3),
    .DATA_W (16),
    .DEPTH  (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .mode           (mode),
    .clr_error      (clr_error),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_data       (out_data),
    .out_id         (out_id),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .pending        (pending),
    .overflow_error (overflow_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_beat(input logic [1:0] id, input logic [15:0] d);
    beat_t b;
    b.id   = id;
    b.data = d;
    sb.push_back(b);
  endtask

  task automatic set_data(input logic [15:0] d0, input logic [15:0] d1, input logic [15:0] d2);
    in_data = {d2, d1, d0};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // A beat is consumed at the next rising edge when out_valid & out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      chk("beat_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mb = sb.pop_front();
        chk("beat_id", 32'(out_id), 32'(mb.id));
        chk("beat_data", 32'(out_data), 32'(mb.data));
      end
    end
  end

  initial begin
    enable = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_id", 32'(out_id), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_overflow", 32'(overflow_error), 32'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'h7);

    // Fixed priority, one simultaneous sample per channel
    step();
    set_data(16'h9ABC, 16'h1234, 16'h5678);
    in_valid = 3'b111;
    expect_beat(2'd0, 16'h9ABC);
    expect_beat(2'd1, 16'h1234);
    expect_beat(2'd2, 16'h5678);
    step();
    in_valid = 3'b000;
    @(negedge clk);
    chk("t1_pending", 32'(pending), 32'h7);
    chk("t1_not_yet_valid", 32'(out_valid), 32'd0);
    step();
    @(negedge clk);
    chk("t1_latency_valid", 32'(out_valid), 32'd1);
    chk("t1_pending_after_grant", 32'(pending), 32'h6);
    repeat (3) begin
      step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
    @(negedge clk);
    chk("t1_drained_valid", 32'(out_valid), 32'd0);
    chk("t1_drained_pending", 32'(pending), 32'd0);
    chk("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Round-robin, two samples per channel, downstream always ready
    step();
    mode = ARB_RR;
    out_ready = 1'b1;
    set_data(16'h1001, 16'h2001, 16'h3001);
    in_valid = 3'b111;
    expect_beat(2'd0, 16'h1001);
    expect_beat(2'd1, 16'h2001);
    expect_beat(2'd2, 16'h3001);
    expect_beat(2'd0, 16'h1002);
    expect_beat(2'd1, 16'h2002);
    expect_beat(2'd2, 16'h3002);
    step();
    set_data(16'h1002, 16'h2002, 16'h3002);
    step();
    in_valid = 3'b000;
    repeat (6) begin
      @(negedge clk);
      chk("t2_back_to_back_valid", 32'(out_valid), 32'd1);
    end
    @(negedge clk);
    chk("t2_idle_after", 32'(out_valid), 32'd0);
    chk("t2_no_overflow", 32'(overflow_error), 32'd0);
    step();
    out_ready = 1'b0;
    mode = ARB_FIXED;

    // Overflow on ch1 while the output slot is occupied
    step();
    set_data(16'h0000, 16'h0000, 16'h0C0C);
    in_valid = 3'b100;
    expect_beat(2'd2, 16'h0C0C);
    step();
    in_valid = 3'b010;
    set_data(16'h0000, 16'h0001, 16'h0000);
    expect_beat(2'd1, 16'h0001);
    step();
    set_data(16'h0000, 16'h0002, 16'h0000);
    expect_beat(2'd1, 16'h0002);
    step();
    set_data(16'h0000, 16'h0003, 16'h0000);
    @(negedge clk);
    chk("t3_in_ready_full", 32'(in_ready), 32'h5);
    chk("t3_no_ovf_yet", 32'(overflow_error), 32'd0);
    chk("t3_pending", 32'(pending), 32'h2);
    step();
    in_valid = 3'b000;
    @(negedge clk);
    chk("t3_ovf_set", 32'(overflow_error), 32'd1);
    step();
    out_ready = 1'b1;
    step();
    step();
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t3_drained_valid", 32'(out_valid), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow_error), 32'd1);
    chk("t3_drained_pending", 32'(pending), 32'd0);
    step();
    clr_error = 1'b1;
    step();
    clr_error = 1'b0;
    @(negedge clk);
    chk("t3_ovf_cleared", 32'(overflow_error), 32'd0);

    // Backpressure hold with a higher-priority arrival
    step();
    set_data(16'h0000, 16'h0000, 16'h5678);
    in_valid = 3'b100;
    expect_beat(2'd2, 16'h5678);
    step();
    in_valid = 3'b000;
    step();
    set_data(16'hAAAA, 16'h0000, 16'h0000);
    in_valid = 3'b001;
    expect_beat(2'd0, 16'hAAAA);
    step();
    in_valid = 3'b000;
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(out_valid), 32'd1);
      chk("t4_hold_id", 32'(out_id), 32'd2);
      chk("t4_hold_data", 32'(out_data), 32'h5678);
    end
    @(negedge clk);
    chk("t4_ch0_waiting", 32'(pending), 32'h1);
    step();
    out_ready = 1'b1;
    step();
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("t4_drained_valid", 32'(out_valid), 32'd0);

    // Enable gating with two samples queued behind the slot
    step();
    set_data(16'h0F0F, 16'h1111, 16'h2222);
    in_valid = 3'b111;
    expect_beat(2'd0, 16'h0F0F);
    expect_beat(2'd1, 16'h1111);
    expect_beat(2'd2, 16'h2222);
    step();
    in_valid = 3'b000;
    step();
    enable = 1'b0;
    set_data(16'hDEAD, 16'hBEEF, 16'hCAFE);
    in_valid = 3'b111;
    @(negedge clk);
    chk("t5_in_ready_off", 32'(in_ready), 32'd0);
    chk("t5_pending_kept", 32'(pending), 32'h6);
    chk("t5_slot_valid", 32'(out_valid), 32'd1);
    chk("t5_slot_id", 32'(out_id), 32'd0);
    step();
    out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("t5_no_grant", 32'(out_valid), 32'd0);
    chk("t5_pending_still", 32'(pending), 32'h6);
    chk("t5_no_overflow", 32'(overflow_error), 32'd0);
    step();
    in_valid = 3'b000;
    enable = 1'b1;
    step();
    step();
    step();
    @(negedge clk);
    chk("t5_drained_valid", 32'(out_valid), 32'd0);
    chk("t5_drained_pending", 32'(pending), 32'd0);
    step();
    out_ready = 1'b0;

    // Asynchronous reset with a beat in flight
    mode = ARB_RR;
    step();
    set_data(16'h0000, 16'h7777, 16'h8888);
    in_valid = 3'b110;
    step();
    in_valid = 3'b100;
    set_data(16'h0000, 16'h0000, 16'h8889);
    step();
    step();
    in_valid = 3'b000;
    @(negedge clk);
    chk("t6_pre_valid", 32'(out_valid), 32'd1);
    chk("t6_pre_pending", 32'(pending), 32'h4);
    chk("t6_pre_ovf", 32'(overflow_error), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_async_valid", 32'(out_valid), 32'd0);
    chk("t6_async_pending", 32'(pending), 32'd0);
    chk("t6_async_ovf", 32'(overflow_error), 32'd0);
    chk("t6_async_in_ready", 32'(in_ready), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    set_data(16'h0A0A, 16'h0B0B, 16'h0C0D);
    in_valid = 3'b111;
    expect_beat(2'd0, 16'h0A0A);
    expect_beat(2'd1, 16'h0B0B);
    expect_beat(2'd2, 16'h0C0D);
    step();
    in_valid = 3'b000;
    step();
    @(negedge clk);
    chk("t6_first_rr_id", 32'(out_id), 32'd0);
    chk("t6_first_rr_valid", 32'(out_valid), 32'd1);
    step();
    step();
    step();
    @(negedge clk);
    chk("t6_drained_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    chk("final_sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
